// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store memory port: access sizes, FSM states,
// lane width and a size-to-byte-count helper.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam int unsigned LANE_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StResp
  } lsu_state_t;

  // Illegal size reports 4 bytes; it is rejected by the size check anyway.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    unique case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Core request/response channel plus RAM port of the load/store initiator.
interface lsu_mem_port_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/lsu_align.sv
// Lane steering: extracts and extends load data from a RAM word, and merges
// sub-word store data into a RAM word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [4:0]  sh;
  logic [15:0] shifted;
  logic [31:0] mask;

  assign sh      = 5'(32'(addr_lo_i) * LANE_W);
  assign shifted = 16'(word_i >> sh);

  always_comb begin
    load_o = word_i;
    mask   = 32'hffff_ffff;
    unique case (size_i)
      SZ_BYTE: begin
        load_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
        mask   = 32'h0000_00ff << sh;
      end
      SZ_HALF: begin
        load_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
        mask   = 32'h0000_ffff << sh;
      end
      default: ;
    endcase
    // Word accesses are aligned, so sh is zero and the merge passes wdata through.
    merged_o = (word_i & ~mask) | ((wdata_i << sh) & mask);
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Single-outstanding load/store initiator for one port of the shared RAM;
// sub-word stores are done as read-modify-write.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input logic            m_clock,
  input logic            p_reset_n,
  lsu_mem_port_if.slave  bus
);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        store_q, store_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic [32:0] end_addr;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign end_addr = {1'b0, bus.req_addr} + 33'(size_bytes(bus.req_size));
  assign req_err  = (bus.req_size == SZ_ILL)
                  | ((bus.req_size == SZ_HALF) & bus.req_addr[0])
                  | ((bus.req_size == SZ_WORD) & (|bus.req_addr[1:0]))
                  | (end_addr > 33'(MEM_BYTES));

  lsu_align u_align (
    .addr_lo_i  (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .word_i     (bus.mem_rdata),
    .wdata_i    (wdata_q),
    .load_o     (load_data),
    .merged_o   (merged_word)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    store_d      = store_q;
    unsigned_d   = unsigned_q;
    wdata_d      = wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_wdata_d  = mem_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          addr_d       = bus.req_addr;
          size_d       = bus.req_size;
          store_d      = bus.req_store;
          unsigned_d   = bus.req_unsigned;
          wdata_d      = bus.req_wdata;
          resp_rdata_d = '0;
          resp_err_d   = req_err;
          if (req_err) begin
            state_d = StResp;
          end else if (bus.req_store && (bus.req_size == SZ_WORD)) begin
            mem_wdata_d = bus.req_wdata;
            state_d     = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (store_q) begin
          mem_wdata_d = merged_word;
          state_d     = StWrite;
        end else begin
          resp_rdata_d = load_data;
          state_d      = StResp;
        end
      end
      StWrite: state_d = StResp;
      StResp: begin
        if (bus.resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      size_q       <= SZ_BYTE;
      store_q      <= 1'b0;
      unsigned_q   <= 1'b0;
      wdata_q      <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      store_q      <= store_d;
      unsigned_q   <= unsigned_d;
      wdata_q      <= wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = (state_q == StResp);
  assign bus.mem_we     = (state_q == StWrite);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_addr   = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: byte-array RAM, byte-level reference model and a
// per-cycle output monitor, driven by directed requests.
module tb_lsu_mem_port;

  localparam int unsigned MemBytes = 4096;

  logic clk;
  logic rst_n;

  lsu_mem_port_if bus ();

  lsu_mem_port #(.MEM_BYTES(MemBytes)) dut (
    .m_clock   (clk),
    .p_reset_n (rst_n),
    .bus       (bus)
  );

  logic [7:0] ram     [MemBytes];
  logic [7:0] ref_mem [MemBytes];

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_rdata, exp_waddr, exp_wword;
  bit          exp_err, exp_write, outstanding;
  int          exp_lat, we_cnt, last_lat;
  logic [11:0] rbase, wbase;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational-read RAM with whole-word write.
  always_comb begin
    rbase         = {bus.mem_addr[11:2], 2'b00};
    bus.mem_rdata = {ram[rbase + 12'd3], ram[rbase + 12'd2], ram[rbase + 12'd1], ram[rbase]};
  end

  always @(posedge clk) begin
    if (bus.mem_we) begin
      wbase = {bus.mem_addr[11:2], 2'b00};
      ram[wbase]          <= bus.mem_wdata[7:0];
      ram[wbase + 12'd1]  <= bus.mem_wdata[15:8];
      ram[wbase + 12'd2]  <= bus.mem_wdata[23:16];
      ram[wbase + 12'd3]  <= bus.mem_wdata[31:24];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ram_word(input int a);
    return {ram[12'(a + 3)], ram[12'(a + 2)], ram[12'(a + 1)], ram[12'(a)]};
  endfunction

  // Reference model: byte-addressed memory and the request rules.
  task automatic model(input bit st, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd);
    int          n;
    int          base;
    logic [31:0] v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    exp_err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
           || (({32'd0, a} + 64'(n)) > 64'(MemBytes));
    exp_write = !exp_err && st;
    exp_rdata = '0;
    if (exp_err) begin
      exp_lat = 1;
    end else if (!st) begin
      v = '0;
      for (int i = 0; i < n; i++) v |= 32'(ref_mem[12'(int'(a) + i)]) << (8 * i);
      if (!uns && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
      exp_rdata = v;
      exp_lat   = 2;
    end else begin
      for (int i = 0; i < n; i++) ref_mem[12'(int'(a) + i)] = wd[8*i +: 8];
      base      = int'(a) & ~3;
      exp_waddr = 32'(base);
      exp_wword = {ref_mem[12'(base + 3)], ref_mem[12'(base + 2)],
                   ref_mem[12'(base + 1)], ref_mem[12'(base)]};
      exp_lat   = (n == 4) ? 2 : 3;
    end
  endtask

  // Per-cycle compare of the response and RAM-write outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_we) begin
        we_cnt++;
        chk("mem_we_allowed", 32'(bus.mem_we), 32'(exp_write));
        chk("mem_addr_on_write", bus.mem_addr, exp_waddr);
        chk("mem_wdata_on_write", bus.mem_wdata, exp_wword);
      end
      if (bus.resp_valid) begin
        chk("resp_valid_expected", 32'(bus.resp_valid), 32'(outstanding));
        chk("resp_rdata", bus.resp_rdata, exp_rdata);
        chk("resp_err", 32'(bus.resp_err), 32'(exp_err));
      end
    end
  end

  task automatic issue(input bit st, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_store    = st;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    chk("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    model(st, sz, uns, a, wd);
    we_cnt      = 0;
    outstanding = 1'b1;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      lat++;
      if (bus.resp_valid) return;
    end
    lat = -1;
  endtask

  task automatic do_req(input bit st, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit pin_en, input logic [31:0] pin, input string tag);
    int lat;
    issue(st, sz, uns, a, wd);
    wait_resp(lat);
    last_lat = lat;
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_err"}, 32'(bus.resp_err), 32'(exp_err));
    chk({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
    chk({tag, "_we_pulses"}, 32'(we_cnt), 32'(exp_write));
    if (pin_en) begin
      chk({tag, "_model_pin"}, exp_rdata, pin);
      chk({tag, "_dut_pin"}, bus.resp_rdata, pin);
    end
    @(posedge clk);
    #1;
    outstanding = 1'b0;
    chk({tag, "_req_ready_after"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] held;
    logic [7:0]  saved [4];

    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_store    = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.resp_ready   = 1'b1;
    outstanding      = 1'b0;
    exp_write        = 1'b0;
    exp_err          = 1'b0;
    exp_rdata        = '0;
    exp_waddr        = '0;
    exp_wword        = '0;
    we_cnt           = 0;
    for (int i = 0; i < int'(MemBytes); i++) begin
      ram[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end

    #3;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store/load
    do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0, "st_w100");
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF, "ld_w100");
    chk("ld_w100_lat_pin", 32'(last_lat), 32'd2);

    // Byte read-modify-write
    do_req(1'b1, 2'd2, 1'b0, 32'h200, 32'h11223344, 1'b0, 32'h0, "st_w200");
    do_req(1'b1, 2'd0, 1'b0, 32'h202, 32'h000000AA, 1'b0, 32'h0, "st_b202");
    chk("st_b202_lat_pin", 32'(last_lat), 32'd3);
    do_req(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 1'b1, 32'h11AA3344, "ld_w200");

    // Extension
    do_req(1'b1, 2'd2, 1'b0, 32'h300, 32'h80FF7F01, 1'b0, 32'h0, "st_w300");
    do_req(1'b0, 2'd0, 1'b0, 32'h302, 32'h0, 1'b1, 32'hFFFFFFFF, "ld_sb302");
    do_req(1'b0, 2'd1, 1'b1, 32'h302, 32'h0, 1'b1, 32'h000080FF, "ld_uh302");
    do_req(1'b0, 2'd0, 1'b0, 32'h301, 32'h0, 1'b1, 32'h0000007F, "ld_sb301");
    do_req(1'b0, 2'd1, 1'b0, 32'h300, 32'h0, 1'b1, 32'h00007F01, "ld_sh300");
    do_req(1'b0, 2'd0, 1'b1, 32'h303, 32'h0, 1'b1, 32'h00000080, "ld_ub303");
    do_req(1'b1, 2'd1, 1'b0, 32'h302, 32'h1234BEEF, 1'b0, 32'h0, "st_h302");
    do_req(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 1'b1, 32'hBEEF7F01, "ld_w300");

    // Errors and range boundary
    do_req(1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 1'b1, 32'h0, "ld_h101_err");
    chk("ld_h101_lat_pin", 32'(last_lat), 32'd1);
    do_req(1'b1, 2'd2, 1'b0, 32'hFFC, 32'h12345678, 1'b0, 32'h0, "st_wffc");
    do_req(1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0, 1'b1, 32'h12345678, "ld_wffc");
    do_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0, "ld_w1000_err");
    do_req(1'b1, 2'd2, 1'b0, 32'h1000, 32'hFFFFFFFF, 1'b0, 32'h0, "st_w1000_err");
    do_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, "ld_illegal_err");
    do_req(1'b1, 2'd1, 1'b0, 32'h203, 32'hFFFF, 1'b0, 32'h0, "st_h203_err");
    do_req(1'b1, 2'd0, 1'b0, 32'hFFF, 32'h0000009C, 1'b0, 32'h0, "st_bfff");
    do_req(1'b0, 2'd0, 1'b1, 32'hFFF, 32'h0, 1'b1, 32'h0000009C, "ld_ubfff");
    do_req(1'b0, 2'd1, 1'b1, 32'hFFF, 32'h0, 1'b1, 32'h0, "ld_hfff_err");

    // Backpressure with an ignored extra request
    bus.resp_ready = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
    wait_resp(lat);
    chk("bp_latency", 32'(lat), 32'd2);
    held = bus.resp_rdata;
    chk("bp_first_rdata", held, 32'h11AA3344);
    bus.req_valid = 1'b1;
    bus.req_store = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h400;
    bus.req_wdata = 32'h55555555;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_resp_valid_held", 32'(bus.resp_valid), 32'd1);
      chk("bp_rdata_held", bus.resp_rdata, held);
      chk("bp_req_ready_low", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    outstanding = 1'b0;
    chk("bp_req_ready_after", 32'(bus.req_ready), 32'd1);
    chk("bp_ignored_store_ram", ram_word(32'h400), 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0, "ld_w400");

    // Reset during the READ phase of a byte store
    do_req(1'b1, 2'd2, 1'b0, 32'h204, 32'hCAFEF00D, 1'b0, 32'h0, "st_w204");
    for (int i = 0; i < 4; i++) saved[i] = ref_mem[12'(32'h204 + i)];
    issue(1'b1, 2'd0, 1'b0, 32'h204, 32'h00000011);
    for (int i = 0; i < 4; i++) ref_mem[12'(32'h204 + i)] = saved[i];
    exp_write   = 1'b0;
    outstanding = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("mid_rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("mid_rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("mid_rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("mid_rst_mem_addr", bus.mem_addr, 32'd0);
    chk("mid_rst_mem_wdata", bus.mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_ram_204", ram_word(32'h204), 32'hCAFEF00D);
    do_req(1'b0, 2'd2, 1'b0, 32'h204, 32'h0, 1'b1, 32'hCAFEF00D, "ld_w204");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
